coord_uart_framer: RTL and testbench
====================================

# coord_uart_framer

Transmit-side framer for the debug UART link. It packs each detected ball coordinate into a fixed byte frame and paces the bytes into the UART transmitter's `tx_data`/`tx_trig` strobe interface, one byte per UART character slot. It sits between the ball-position logic and the UART top, and is the outbound counterpart of the 4-byte threshold receive path. The host parses a frame as: header, payload, optional checksum.

## Interface
Parameters:
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `UART_BPS`, default 9600: UART baud rate.
- `SLOT_CYCLES`, default (CLK_FREQ/UART_BPS)*11: clocks per byte slot (10 bit times plus 1 guard bit).

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `coord_valid`, in, 1: single-cycle strobe; `coord_x`/`coord_y` are valid in that cycle.
- `coord_x`, in, 11: ball X coordinate (0–2047).
- `coord_y`, in, 10: ball Y coordinate (0–1023).
- `tx_data`, out, 8: byte to transmit; held stable for the whole slot.
- `tx_trig`, out, 1: one-cycle strobe that starts transmission of `tx_data`.
- `busy`, out, 1: high while a frame is in flight.
- `frame_done`, out, 1: one-cycle pulse at the end of the last byte slot of a frame.
- `drop_cnt`, out, 8: saturating count of coordinates that were overwritten before being sent.

## Operation
- Frame byte order:
  - 0xA5 (header)
  - {5'b0, X[10:8]}, X[7:0]
  - {6'b0, Y[9:8]}, Y[7:0]
  - checksum (only when configured; see Configuration)
- State machine: IDLE -> SEND -> WAIT -> (SEND for the next byte | IDLE).
  - IDLE: `busy`=0. On `coord_valid`, latch X/Y into the frame register, clear the byte index, and go to SEND.
  - SEND: drive `tx_data` = frame[idx], pulse `tx_trig` for one cycle, load the slot counter, go to WAIT.
  - WAIT: count down SLOT_CYCLES−1 cycles. At expiry, if idx is not the last byte, increment idx and go to SEND. Otherwise pulse `frame_done` and either go to IDLE or start the next frame (see next bullet).
- Pending slot: one entry deep.
  - `coord_valid` while `busy` writes the pending register.
  - If the pending register already held a value, the old value is discarded and `drop_cnt` increments, saturating at 255.
  - At frame end with pending valid, the pending value is loaded and the next frame goes straight to SEND; no idle cycle.
- Simultaneous events:
  - `coord_valid` in the same cycle as frame end: the new coordinate is used. Any older pending value counts as a drop.
  - `coord_valid` in the SEND cycle: goes to pending. The frame in flight is never altered.
- Reset: all state cleared immediately. Any frame in progress is aborted with no completion pulse. Reset values: `tx_data`=0, `tx_trig`=0, `busy`=0, `frame_done`=0, `drop_cnt`=0, pending slot empty.

## Timing
- Latency: `coord_valid` at cycle N in IDLE gives the first `tx_trig` at N+1 with `tx_data`=0xA5.
- `busy` rises at N+1.
- Byte k strobe is at N+1+k*SLOT_CYCLES.
- `frame_done` is at N+B*SLOT_CYCLES, where B = 5 or 6 bytes per frame.
- `busy` falls the cycle after `frame_done` unless a back-to-back frame starts.
- Back-to-back frames: the next header `tx_trig` is exactly SLOT_CYCLES after the previous frame's last `tx_trig`.
- `tx_trig` is never high on two consecutive cycles. Its minimum spacing is SLOT_CYCLES.

## Configuration
- `COORD_FRAME_CHKSUM_EN` defined:
  - A 6th byte is appended: the 8-bit modulo-256 sum of the four payload bytes (header excluded).
  - B=6.
- Not defined:
  - The frame ends after Y[7:0]; no checksum logic is present.
  - B=5.

## Test plan
Use CLK_FREQ=1000 and UART_BPS=100 (SLOT_CYCLES=110) for all directed tests.
- Single frame: X=640, Y=480 -> bytes A5, 02, 80, 01, E0, and with checksum enabled 63. Strobes at N+1, +110 each. `frame_done` at N+660 (checksum) or N+550 (no checksum).
- Back-to-back: a second `coord_valid` (X=5, Y=7) mid-frame -> the second frame's header strobe comes 110 cycles after the first frame's last strobe. `busy` stays high throughout. `drop_cnt`=0.
- Overwrite: three `coord_valid` during one frame -> only the last value is sent next. `drop_cnt`=1.
- Boundaries: X=2047, Y=1023 -> bytes 07, FF, 03, FF, checksum 0x08. Drives 256+ overwrites -> `drop_cnt` saturates at FF.
- Reset mid-frame: assert `rst` during byte 3's WAIT -> all outputs reset immediately, with no `frame_done`. After release, a new `coord_valid` starts a clean frame with header A5.
- Coincident events: `coord_valid` in the exact frame-end cycle -> the new frame's header `tx_trig` arrives on the next cycle.

Source files
------------

// File: rtl/coord_uart_framer.sv
// coord_uart_framer: packs ball coordinates into header/payload UART byte frames, one byte per slot.
// Optional checksum byte is enabled by defining COORD_FRAME_CHKSUM_EN (default build: 5-byte frames).
module coord_uart_framer #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int UART_BPS    = 9600,
    parameter int SLOT_CYCLES = (CLK_FREQ / UART_BPS) * 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        coord_valid,
    input  logic [10:0] coord_x,
    input  logic [9:0]  coord_y,
    output logic [7:0]  tx_data,
    output logic        tx_trig,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  drop_cnt
);
`ifdef COORD_FRAME_CHKSUM_EN
    localparam logic [2:0] LAST = 3'd5;
`else
    localparam logic [2:0] LAST = 3'd4;
`endif
    localparam int CW = $clog2(SLOT_CYCLES);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(SLOT_CYCLES - 2);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t        state_q;
    logic [2:0]    idx_q;
    logic [CW-1:0] cnt_q;
    logic [10:0]   x_q, pend_x_q;
    logic [9:0]    y_q, pend_y_q;
    logic          pend_v_q;
    logic [7:0]    tx_data_q, drop_cnt_q;
    logic          tx_trig_q, busy_q, frame_done_q;
    logic          slot_end, frame_end;
    logic [10:0]   next_x;
    logic [9:0]    next_y;

    function automatic logic [7:0] frame_byte(input logic [10:0] x, input logic [9:0] y, input logic [2:0] i);
        case (i)
            3'd0: frame_byte = 8'hA5;
            3'd1: frame_byte = {5'b0, x[10:8]};
            3'd2: frame_byte = x[7:0];
            3'd3: frame_byte = {6'b0, y[9:8]};
            3'd4: frame_byte = y[7:0];
`ifdef COORD_FRAME_CHKSUM_EN
            3'd5: frame_byte = {5'b0, x[10:8]} + x[7:0] + {6'b0, y[9:8]} + y[7:0];
`endif
            default: frame_byte = 8'h00;
        endcase
    endfunction

    assign slot_end   = state_q == WAIT && cnt_q == '0;
    assign frame_end  = slot_end && idx_q == LAST;
    // A coordinate arriving on the frame-end cycle beats the older pending one.
    assign next_x     = coord_valid ? coord_x : pend_x_q;
    assign next_y     = coord_valid ? coord_y : pend_y_q;
    assign tx_data    = tx_data_q;
    assign tx_trig    = tx_trig_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign drop_cnt   = drop_cnt_q;

    // Frame sequencer: outputs are registered on the edge that enters each state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            tx_data_q    <= '0;
            tx_trig_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            tx_trig_q    <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: if (coord_valid) begin
                    x_q       <= coord_x;
                    y_q       <= coord_y;
                    idx_q     <= '0;
                    tx_data_q <= 8'hA5;
                    tx_trig_q <= 1'b1;
                    busy_q    <= 1'b1;
                    state_q   <= SEND;
                end
                SEND: begin
                    cnt_q        <= WAIT_LOAD;
                    frame_done_q <= WAIT_LOAD == '0 && idx_q == LAST;
                    state_q      <= WAIT;
                end
                WAIT: if (cnt_q != '0) begin
                    cnt_q        <= cnt_q - 1'b1;
                    frame_done_q <= cnt_q == CW'(1) && idx_q == LAST;
                end else if (idx_q != LAST) begin
                    idx_q     <= idx_q + 3'd1;
                    tx_data_q <= frame_byte(x_q, y_q, idx_q + 3'd1);
                    tx_trig_q <= 1'b1;
                    state_q   <= SEND;
                end else if (coord_valid || pend_v_q) begin
                    x_q       <= next_x;
                    y_q       <= next_y;
                    idx_q     <= '0;
                    tx_data_q <= 8'hA5;
                    tx_trig_q <= 1'b1;
                    state_q   <= SEND;
                end else begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // One-deep pending slot and saturating overwrite counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_v_q   <= 1'b0;
            pend_x_q   <= '0;
            pend_y_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (frame_end) begin
                pend_v_q <= 1'b0;
            end else if (coord_valid && state_q != IDLE) begin
                pend_v_q <= 1'b1;
                pend_x_q <= coord_x;
                pend_y_q <= coord_y;
            end
            if (coord_valid && pend_v_q && state_q != IDLE && drop_cnt_q != 8'hFF)
                drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end
endmodule

// File: tb/tb_coord_uart_framer.sv
// tb_coord_uart_framer: randomized + directed scoreboard bench for coord_uart_framer.
module tb_coord_uart_framer;
    localparam int S = 110;
`ifdef COORD_FRAME_CHKSUM_EN
    localparam int B = 6;
`else
    localparam int B = 5;
`endif

    typedef struct {
        logic [7:0] b;
        int         t;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        coord_valid = 1'b0;
    logic [10:0] coord_x = '0;
    logic [9:0]  coord_y = '0;
    logic [7:0]  tx_data;
    logic        tx_trig;
    logic        busy;
    logic        frame_done;
    logic [7:0]  drop_cnt;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    ev_t  exp_q[$];
    int   done_q[$];
    ev_t  mon_e;
    int   mon_t;
    bit   m_act = 0;
    bit   m_pv = 0;
    int   m_px, m_py, m_end;
    int   m_drops = 0;

    coord_uart_framer #(.CLK_FREQ(1000), .UART_BPS(100)) dut (
        .clk(clk), .rst(rst), .coord_valid(coord_valid), .coord_x(coord_x), .coord_y(coord_y),
        .tx_data(tx_data), .tx_trig(tx_trig), .busy(busy), .frame_done(frame_done), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
        end
    endtask

    // Reference model: a frame started in cycle n emits byte k at n+1+k*S and completes at n+B*S.
    task automatic start_frame(input int x, input int y);
        int bytes[6];
        bytes[0] = 'hA5;
        bytes[1] = x / 256;
        bytes[2] = x % 256;
        bytes[3] = y / 256;
        bytes[4] = y % 256;
        bytes[5] = (bytes[1] + bytes[2] + bytes[3] + bytes[4]) % 256;
        for (int k = 0; k < B; k++) exp_q.push_back('{8'(bytes[k]), cyc + 1 + k * S});
        m_end = cyc + B * S;
        done_q.push_back(m_end);
        m_act = 1;
    endtask

    task automatic drop();
        if (m_drops < 255) m_drops++;
    endtask

    initial forever begin
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            done_q.delete();
            m_act = 0;
            m_pv = 0;
            m_drops = 0;
        end else if (m_act && cyc == m_end) begin
            if (coord_valid) begin
                if (m_pv) drop();
                m_pv = 0;
                start_frame(int'(coord_x), int'(coord_y));
            end else if (m_pv) begin
                m_pv = 0;
                start_frame(m_px, m_py);
            end else begin
                m_act = 0;
            end
        end else if (m_act) begin
            if (coord_valid) begin
                if (m_pv) drop();
                m_pv = 1;
                m_px = int'(coord_x);
                m_py = int'(coord_y);
            end
        end else if (coord_valid) begin
            start_frame(int'(coord_x), int'(coord_y));
        end
        cyc++;
    end

    // Monitor: pops the scoreboard whenever the DUT strobes a byte or completes a frame.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (tx_trig) begin
                if (exp_q.size() == 0) chk("unexpected_trig", 1, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("tx_byte", int'(tx_data), int'(mon_e.b));
                    chk("trig_cycle", cyc, mon_e.t);
                end
            end
            if (frame_done) begin
                if (done_q.size() == 0) chk("unexpected_frame_done", 1, 0);
                else begin
                    mon_t = done_q.pop_front();
                    chk("frame_done_cycle", cyc, mon_t);
                end
            end
            chk("busy", int'(busy), int'(m_act));
            chk("drop_cnt", int'(drop_cnt), m_drops);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int x, input int y);
        coord_valid = 1'b1;
        coord_x = 11'(x);
        coord_y = 10'(y);
        tick();
        coord_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 5000 && busy; i++) tick();
        chk("idle_timeout", int'(busy), 0);
        tick();
    endtask

    task automatic chk_reset_outputs();
        chk("rst_tx_data", int'(tx_data), 0);
        chk("rst_tx_trig", int'(tx_trig), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_drop_cnt", int'(drop_cnt), 0);
    endtask

    initial begin
        int c;
        repeat (3) tick();
        chk_reset_outputs();
        rst = 1'b0;
        tick();
        send(640, 480);
        wait_idle();
        send(640, 480);
        send(5, 7);
        wait_idle();
        send(10, 20);
        repeat (40) tick();
        send(30, 40);
        repeat (40) tick();
        send(50, 60);
        wait_idle();
        send(2047, 1023);
        wait_idle();
        c = cyc;
        send(1, 2);
        while (cyc < c + B * S) tick();
        send(3, 4);
        wait_idle();
        for (int i = 0; i < 15; i++) begin
            send(int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)));
            repeat ($urandom_range(0, 700)) tick();
        end
        wait_idle();
        for (int i = 0; i < 300; i++) send(int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)));
        chk("drop_saturated", int'(drop_cnt), 255);
        wait_idle();
        c = cyc;
        send(100, 200);
        while (cyc < c + 1 + 3 * S + 20) tick();
        rst = 1'b1;
        #1;
        chk_reset_outputs();
        repeat (3) tick();
        rst = 1'b0;
        tick();
        send(9, 9);
        wait_idle();
        repeat (5) tick();
        chk("trigs_outstanding", exp_q.size(), 0);
        chk("dones_outstanding", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
